// File: rtl/char_scan_gen_pkg.sv
// Default VGA 640x480@60 timing and text-cell geometry shared by the
// character scan generator and its counters.
package char_scan_gen_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CELL_W     = 8;
  localparam int CELL_H     = 16;
  localparam int CELL_W_LOG = $clog2(CELL_W);
  localparam int CELL_H_LOG = $clog2(CELL_H);

endpackage

// File: rtl/char_scan_gen_scan_counter.sv
// Wrap counter 0..MAX-1 that resets to MAX-1, exposing its next-state value
// so the parent can look ahead without a second counter.
module scan_counter #(
  parameter int MAX   = 800,
  parameter int WIDTH = $clog2(MAX)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] countNext,
  output logic             wrap,
  output logic             nextWrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count;

  assign wrap     = (count == LAST);
  assign nextWrap = (countNext == LAST);

  always_comb begin
    countNext = count;
    if (en) countNext = wrap ? '0 : count + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= LAST;
    else       count <= countNext;
  end

endmodule

// File: rtl/char_scan_gen.sv
// Text-mode raster scan generator: pixel-phase sync/active timing plus a
// one-pixel look-ahead that addresses the glyph fetch for the next cell.
module char_scan_gen
  import char_scan_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixEn,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [2:0] colCnt,
  output logic       colEn,
  output logic       rowEn,
  output logic [3:0] rowCnt,
  output logic [6:0] charCol,
  output logic [4:0] charRow,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hNext, hLook;
  logic [VW-1:0] vNext, vLook;
  logic          hWrap, hNextWrap, vWrap, vNextWrap, vEn;

  assign vEn = hWrap & pixEn;

  scan_counter #(.MAX(H_TOTAL), .WIDTH(HW)) hCounter (
    .clock    (clock),
    .reset    (reset),
    .en       (pixEn),
    .countNext(hNext),
    .wrap     (hWrap),
    .nextWrap (hNextWrap)
  );

  scan_counter #(.MAX(V_TOTAL), .WIDTH(VW)) vCounter (
    .clock    (clock),
    .reset    (reset),
    .en       (vEn),
    .countNext(vNext),
    .wrap     (vWrap),
    .nextWrap (vNextWrap)
  );

  // Position one advance beyond the counters' next state; crosses line and frame ends.
  always_comb begin
    hLook = hNextWrap ? '0 : hNext + 1'b1;
    vLook = vNext;
    if (hNextWrap) vLook = vNextWrap ? '0 : vNext + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      active     <= 1'b0;
      colCnt     <= 3'd0;
      colEn      <= 1'b0;
      rowEn      <= 1'b0;
      rowCnt     <= 4'd0;
      charCol    <= 7'd0;
      charRow    <= 5'd0;
      frameStart <= 1'b0;
    end else if (pixEn) begin
      hsync      <= !(hNext >= HS_START && hNext < HS_END);
      vsync      <= !(vNext >= VS_START && vNext < VS_END);
      active     <= (hNext < H_ACT_L) && (vNext < V_ACT_L);
      colCnt     <= 3'd7 - hNext[2:0];
      colEn      <= (hLook[2:0] == 3'd0) && (hLook < H_ACT_L) && (vLook < V_ACT_L);
      rowEn      <= (vLook < V_ACT_L);
      rowCnt     <= vLook[3:0];
      charCol    <= 7'(hLook >> CELL_W_LOG);
      charRow    <= 5'(vLook >> CELL_H_LOG);
      frameStart <= hWrap & vWrap;
    end else begin
      colEn      <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_char_scan_gen.sv
// Bench for char_scan_gen: default-timing instance plus a shrunken-timing
// instance so whole frames fit in a short run.
module tb_char_scan_gen;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [2:0] colCnt;
    logic       colEn;
    logic       rowEn;
    logic [3:0] rowCnt;
    logic [6:0] charCol;
    logic [4:0] charRow;
    logic       frameStart;
  } outs_t;

  typedef struct packed {
    int hA; int hF; int hS; int hB;
    int vA; int vF; int vS; int vB;
  } p_t;

  typedef struct {
    int    n;
    outs_t exp;
  } vec_t;

  localparam p_t PA = '{hA:640, hF:16, hS:96, hB:48, vA:480, vF:10, vS:2, vB:33};
  localparam p_t PB = '{hA:64,  hF:4,  hS:8,  hB:4,  vA:32,  vF:2,  vS:2, vB:3};
  localparam int HTB = 80;
  localparam int FRB = 3120;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pixEn = 1'b0;

  logic aHsync, aVsync, aActive, aColEn, aRowEn, aFrameStart;
  logic [2:0] aColCnt; logic [3:0] aRowCnt; logic [6:0] aCharCol; logic [4:0] aCharRow;
  logic bHsync, bVsync, bActive, bColEn, bRowEn, bFrameStart;
  logic [2:0] bColCnt; logic [3:0] bRowCnt; logic [6:0] bCharCol; logic [4:0] bCharRow;
  outs_t aOut, bOut;

  assign aOut = {aHsync, aVsync, aActive, aColCnt, aColEn, aRowEn, aRowCnt, aCharCol, aCharRow, aFrameStart};
  assign bOut = {bHsync, bVsync, bActive, bColCnt, bColEn, bRowEn, bRowCnt, bCharCol, bCharRow, bFrameStart};

  char_scan_gen dutA (
    .clock(clock), .reset(reset), .pixEn(pixEn),
    .hsync(aHsync), .vsync(aVsync), .active(aActive), .colCnt(aColCnt), .colEn(aColEn),
    .rowEn(aRowEn), .rowCnt(aRowCnt), .charCol(aCharCol), .charRow(aCharRow),
    .frameStart(aFrameStart)
  );

  char_scan_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dutB (
    .clock(clock), .reset(reset), .pixEn(pixEn),
    .hsync(bHsync), .vsync(bVsync), .active(bActive), .colCnt(bColCnt), .colEn(bColEn),
    .rowEn(bRowEn), .rowCnt(bRowCnt), .charCol(bCharCol), .charRow(bCharRow),
    .frameStart(bFrameStart)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int nA, nB;
  outs_t expA, expB, rstOut;

  function automatic outs_t o(bit hs, bit vs, bit act, int cc, bit ce, bit re,
                              int rc, int col, int row, bit fs);
    outs_t r;
    r.hsync = hs; r.vsync = vs; r.active = act; r.colCnt = 3'(cc);
    r.colEn = ce; r.rowEn = re; r.rowCnt = 4'(rc); r.charCol = 7'(col);
    r.charRow = 5'(row); r.frameStart = fs;
    return r;
  endfunction

  // Reference: n-th advance after reset lands on raster index (n-1) mod frame.
  function automatic outs_t expOuts(p_t p, int n);
    int ht, vt, fr, k, kf, h, v, hf, vf;
    outs_t r;
    ht = p.hA + p.hF + p.hS + p.hB;
    vt = p.vA + p.vF + p.vS + p.vB;
    fr = ht * vt;
    k  = (n - 1) % fr;
    kf = (k + 1) % fr;
    h  = k % ht;  v  = k / ht;
    hf = kf % ht; vf = kf / ht;
    r.hsync      = !(h >= p.hA + p.hF && h < p.hA + p.hF + p.hS);
    r.vsync      = !(v >= p.vA + p.vF && v < p.vA + p.vF + p.vS);
    r.active     = (h < p.hA) && (v < p.vA);
    r.colCnt     = 3'(7 - h % 8);
    r.colEn      = (hf % 8 == 0) && (hf < p.hA) && (vf < p.vA);
    r.rowEn      = (vf < p.vA);
    r.rowCnt     = 4'(vf % 16);
    r.charCol    = 7'(hf / 8);
    r.charRow    = 5'(vf / 16);
    r.frameStart = (k == 0);
    return r;
  endfunction

  task automatic checkOut(input string nm, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s got=%h want=%h (nA=%0d nB=%0d)", nm, act, exp, nA, nB);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic pe);
    pixEn = pe;
    @(posedge clock);
    if (pe) begin
      nA++; nB++;
      expA = expOuts(PA, nA);
      expB = expOuts(PB, nB);
    end else begin
      expA.colEn = 1'b0; expA.frameStart = 1'b0;
      expB.colEn = 1'b0; expB.frameStart = 1'b0;
    end
    @(negedge clock);
    checkOut("modelA", aOut, expA);
    checkOut("modelB", bOut, expB);
  endtask

  task automatic doReset();
    reset = 1'b1;
    pixEn = 1'b0;
    nA = 0; nB = 0; expA = rstOut; expB = rstOut;
    repeat (2) @(negedge clock);
    checkOut("resetA", aOut, rstOut);
    checkOut("resetB", bOut, rstOut);
    reset = 1'b0;
  endtask

  vec_t tabA[11];
  vec_t tabB[7];
  int   hq[$];
  int   vq[$];

  initial begin
    int ti, hsLow, hsFirst, fsSeen, since, ceCnt, vsLow, frameLen, frameCe, frameVs;
    int idleCe, cyc, lastFs, cycLen, sbChecks, hExp, vExp;
    logic pe;

    rstOut = o(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    //              hs vs act cc ce re rc col row fs
    tabA[0]  = '{1,     o(1, 1, 1, 7, 0, 1, 0,  0, 0, 1)};
    tabA[1]  = '{8,     o(1, 1, 1, 0, 1, 1, 0,  1, 0, 0)};
    tabA[2]  = '{640,   o(1, 1, 1, 0, 0, 1, 0, 80, 0, 0)};
    tabA[3]  = '{641,   o(1, 1, 0, 7, 0, 1, 0, 80, 0, 0)};
    tabA[4]  = '{656,   o(1, 1, 0, 0, 0, 1, 0, 82, 0, 0)};
    tabA[5]  = '{657,   o(0, 1, 0, 7, 0, 1, 0, 82, 0, 0)};
    tabA[6]  = '{752,   o(0, 1, 0, 0, 0, 1, 0, 94, 0, 0)};
    tabA[7]  = '{753,   o(1, 1, 0, 7, 0, 1, 0, 94, 0, 0)};
    tabA[8]  = '{800,   o(1, 1, 0, 0, 1, 1, 1,  0, 0, 0)};
    tabA[9]  = '{8006,  o(1, 1, 1, 2, 0, 1, 10, 0, 0, 0)};
    tabA[10] = '{12800, o(1, 1, 0, 0, 1, 1, 0,  0, 1, 0)};
    tabB[0]  = '{2560,  o(1, 1, 0, 0, 0, 0, 0,  0, 2, 0)};
    tabB[1]  = '{2561,  o(1, 1, 0, 7, 0, 0, 0,  0, 2, 0)};
    tabB[2]  = '{2721,  o(1, 0, 0, 7, 0, 0, 2,  0, 2, 0)};
    tabB[3]  = '{2880,  o(1, 0, 0, 0, 0, 0, 4,  0, 2, 0)};
    tabB[4]  = '{2881,  o(1, 1, 0, 7, 0, 0, 4,  0, 2, 0)};
    tabB[5]  = '{3120,  o(1, 1, 0, 0, 1, 1, 0,  0, 0, 0)};
    tabB[6]  = '{3121,  o(1, 1, 1, 7, 0, 1, 0,  0, 0, 1)};

    // Default timing: table points through the first 16 lines, hsync window of line 0.
    doReset();
    ti = 0; hsLow = 0; hsFirst = -1;
    for (int i = 0; i < 12800; i++) begin
      step(1'b1);
      if (ti < 11 && nA == tabA[ti].n) begin
        checkOut($sformatf("tabA%0d", ti), aOut, tabA[ti].exp);
        ti++;
      end
      if (nA <= 800 && !aHsync) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = (nA - 1) % 800;
      end
    end
    chk("tabA_reached", ti, 11);
    chk("hsync_low_len", hsLow, 96);
    chk("hsync_low_start", hsFirst, 656);

    // Small timing, pixEn held: frame boundaries and per-frame totals.
    doReset();
    ti = 0; fsSeen = 0; since = 0; ceCnt = 0; vsLow = 0;
    frameLen = -1; frameCe = -1; frameVs = -1;
    for (int i = 0; i < 2 * FRB + 2; i++) begin
      step(1'b1);
      if (ti < 7 && nB == tabB[ti].n) begin
        checkOut($sformatf("tabB%0d", ti), bOut, tabB[ti].exp);
        ti++;
      end
      if (bFrameStart) begin
        if (fsSeen == 1) begin frameLen = since; frameCe = ceCnt; frameVs = vsLow; end
        fsSeen++; since = 0; ceCnt = 0; vsLow = 0;
      end
      since++;
      if (bColEn) ceCnt++;
      if (!bVsync) vsLow++;
    end
    chk("tabB_reached", ti, 7);
    chk("frame_advances", frameLen, FRB);
    chk("frame_colEn", frameCe, (64 / 8) * 32);
    chk("frame_vsync_low", frameVs, 2 * HTB);

    // Alternating strobe: frame takes twice the cycles, no colEn after an idle edge.
    doReset();
    idleCe = 0; cyc = 0; lastFs = -1; cycLen = -1;
    for (int i = 0; i < 2 * 2 * FRB + 4; i++) begin
      pe = (i % 2 == 0);
      step(pe);
      cyc++;
      if (bColEn && !pe) idleCe++;
      if (bFrameStart) begin
        if (lastFs >= 0 && cycLen < 0) cycLen = cyc - lastFs;
        lastFs = cyc;
      end
    end
    chk("toggle_idle_colEn", idleCe, 0);
    chk("toggle_frame_cycles", cycLen, 2 * FRB);

    // Random strobe with fetch scoreboard: each colEn names the next pixel.
    doReset();
    sbChecks = 0;
    for (int i = 0; i < 8000; i++) begin
      pe = ($urandom_range(0, 3) != 0);
      step(pe);
      if (pe && hq.size() > 0) begin
        hExp = hq.pop_front();
        vExp = vq.pop_front();
        chk("sb_hcnt", hExp, (nB - 1) % HTB);
        chk("sb_vcnt", vExp, ((nB - 1) % FRB) / HTB);
        sbChecks++;
      end
      if (bColEn) begin
        hq.push_back(int'(bCharCol) * 8);
        vq.push_back(int'(bCharRow) * 16 + int'(bRowCnt));
      end
    end
    if (sbChecks == 0) chk("sb_activity", sbChecks, 1);

    // Reset mid-frame while hsync is low.
    doReset();
    for (int i = 0; i < 5000 && nB < 20 * HTB + 71; i++) step(1'b1);
    chk("reach_reset_point", nB, 20 * HTB + 71);
    chk("hsync_low_pre_reset", int'(bHsync), 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hsync", int'(bHsync), 1);
    chk("async_rst_colEn", int'(bColEn), 0);
    checkOut("async_rstB", bOut, rstOut);
    checkOut("async_rstA", aOut, rstOut);
    nA = 0; nB = 0; expA = rstOut; expB = rstOut;
    @(negedge clock);
    reset = 1'b0;
    step(1'b1);
    chk("post_rst_frameStartB", int'(bFrameStart), 1);
    chk("post_rst_frameStartA", int'(aFrameStart), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_scan_gen.md
CHAR_SCAN_GEN -- requirements
Module: char_scan_gen

Interface
REQ-001 Parameters SHALL be, one per line: H_ACTIVE 640, visible pixels per line; H_FP 16, horizontal front porch; H_SYNC 96, hsync width; H_BP 48, horizontal back porch; V_ACTIVE 480, visible lines; V_FP 10, vertical front porch; V_SYNC 2, vsync width; V_BP 33, vertical back porch.
REQ-002 Ports SHALL be: clock in 1, system clock; reset in 1, asynchronous active-high reset; pixEn in 1, pixel-rate strobe that advances the scan; hsync out 1, horizontal sync, active-low; vsync out 1, vertical sync, active-low; active out 1, current pixel is visible; colCnt out 3, bit index of the current pixel in its glyph byte; colEn out 1, glyph byte load strobe; rowEn out 1, fetch line is visible; rowCnt out 4, glyph row of the fetched cell; charCol out 7, text column of the fetched cell; charRow out 5, text row of the fetched cell; frameStart out 1, one-cycle pulse at frame start.

Function
REQ-003 The block SHALL hold hCnt 0..H_TOTAL-1 and vCnt 0..V_TOTAL-1, where H_TOTAL is 800 and V_TOTAL is 525 at the default parameters.
REQ-004 Counters SHALL advance only on cycles with pixEn=1; with pixEn=0, all counters and outputs SHALL hold, except colEn and frameStart, which SHALL be 0.
REQ-005 hCnt SHALL wrap H_TOTAL-1->0; vCnt SHALL increment on that wrap and wrap V_TOTAL-1->0.
REQ-006 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-007 Pixel-phase outputs SHALL describe pixel (hCnt,vCnt) in the same cycle the counters hold it.
REQ-008 active SHALL be 1 when hCnt<H_ACTIVE and vCnt<V_ACTIVE.
REQ-009 hsync SHALL be 0 for H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-010 vsync SHALL be 0 for V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-011 colCnt SHALL equal 7 - hCnt[2:0], so glyph bits are displayed MSB-first.
REQ-012 Fetch-phase outputs SHALL look one pixel ahead: they SHALL describe the next pixel position (h',v'), i.e. the counter values after the next advance.
REQ-013 colEn SHALL be 1 for exactly one advancing cycle when h'[2:0]=0, h'<H_ACTIVE, and v'<V_ACTIVE, giving 80 pulses per visible line.
REQ-014 The consumer latches the byte on colEn, so the byte SHALL be in place for the first pixel of the cell.
REQ-015 rowEn SHALL be 1 when v'<V_ACTIVE.
REQ-016 rowCnt SHALL equal v'[3:0], charRow SHALL equal v'[8:4], and charCol SHALL equal h'[9:3].
REQ-017 Fetch-phase values SHALL be stable while colEn=1.
REQ-018 Line-wrap lookahead: at hCnt=H_TOTAL-1, (h',v') SHALL be (0,vCnt+1), or (0,0) when vCnt=V_TOTAL-1.
REQ-019 frameStart SHALL pulse one cycle when the counters advance to (0,0).

Reset
REQ-020 Reset SHALL force hCnt=H_TOTAL-1 and vCnt=V_TOTAL-1, so the first advance lands on (0,0) and raises frameStart.
REQ-021 Output reset values SHALL be: hsync=1, vsync=1, active=0, colCnt=0, colEn=0, rowEn=0, rowCnt=0, charCol=0, charRow=0, frameStart=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse extended.

Structure
REQ-023 A shared package SHALL hold the default timing constants, the derived totals, and the cell geometry CELL_W=8 and CELL_H=16.
REQ-024 One sub-module, scan_counter, SHALL be used: a parameterised wrap counter with an enable input and a wrap output, instantiated once horizontally and once vertically (vertical enable = horizontal wrap AND pixEn).
REQ-025 The look-ahead (h',v') SHALL be derived combinationally from the counter next-state values, not from a second counter pair.

Verification
REQ-026 Reset, then pixEn held 1 -> frameStart on the 1st advance; colEn on the cycle before hCnt=0; hsync low for exactly 96 advances starting at hCnt=656.
REQ-027 Run one full frame with pixEn=1 -> exactly 420000 advances between frameStart pulses; 80x480=38400 colEn pulses; vsync low for 2 lines (1600 advances).
REQ-028 pixEn toggling 1,0,1,0 -> counters advance every other cycle; colEn never 1 on a pixEn=0 cycle; frame length 840000 cycles.
REQ-029 At hCnt=799, vCnt=479 -> rowEn drops to 0; no colEn until vCnt wraps; at hCnt=799, vCnt=524 -> colEn=1 with charCol=0, charRow=0, rowCnt=0.
REQ-030 Reset asserted at hCnt=700 (hsync low), vCnt=200 -> hsync=1, colEn=0 in the same cycle; after release, the first advance gives frameStart.
REQ-031 Scoreboard check -> at each colEn, charCol*8 equals the next hCnt and charRow*16+rowCnt equals the next vCnt.
